// File: rtl/cic_comp_fir_if.sv
// cic_comp_fir_if: sample, coefficient-write and status signals of the CIC compensation FIR.
interface cic_comp_fir_if #(
    parameter int DATA_WIDTH = 12,
    parameter int COEF_WIDTH = 16,
    parameter int NUM_TAPS   = 16
);
    logic signed [DATA_WIDTH-1:0]   data_in;
    logic                           data_clk;
    logic                           coef_we;
    logic [$clog2(NUM_TAPS)-1:0]    coef_addr;
    logic signed [COEF_WIDTH-1:0]   coef_data;
    logic signed [DATA_WIDTH-1:0]   data_out;
    logic                           data_valid;
    logic                           busy;
    logic                           overrun;

    modport master (
        output data_in, data_clk, coef_we, coef_addr, coef_data,
        input  data_out, data_valid, busy, overrun
    );
    modport slave (
        input  data_in, data_clk, coef_we, coef_addr, coef_data,
        output data_out, data_valid, busy, overrun
    );
endinterface

// File: rtl/cic_comp_fir.sv
// cic_comp_fir: sequential single-MAC compensation FIR behind a CIC decimator,
// one tap per clk, programmable Q2 coefficients, saturated registered output.
module cic_comp_fir #(
    parameter int DATA_WIDTH = 12,
    parameter int COEF_WIDTH = 16,
    parameter int NUM_TAPS   = 16,
    parameter int ACC_WIDTH  = 40
) (
    input logic         clk,
    input logic         arst_n,
    cic_comp_fir_if.slave bus
);
    localparam int AW = $clog2(NUM_TAPS);
    localparam int PW = COEF_WIDTH + DATA_WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                        state_q, state_d;
    logic                          data_clk_q, armed_q;
    logic [AW-1:0]                 wr_ptr_q, wr_ptr_d, newest_q, newest_d, k_q, k_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic signed [DATA_WIDTH-1:0]  data_out_q, data_out_d;
    logic                          data_valid_q, data_valid_d, overrun_q, overrun_d;
    logic signed [DATA_WIDTH-1:0]  samp_q [NUM_TAPS];
    logic signed [COEF_WIDTH-1:0]  coef_q [NUM_TAPS];

    logic                          idle, strobe, take;
    logic [AW-1:0]                 rd_idx;
    logic signed [PW-1:0]          prod;
    logic signed [ACC_WIDTH-1:0]   shifted;
    logic signed [DATA_WIDTH-1:0]  sat_out;

    // armed_q keeps a data_clk that is already high at reset release from counting as a strobe
    assign idle    = state_q == IDLE;
    assign strobe  = bus.data_clk & ~data_clk_q & armed_q;
    assign take    = strobe & idle;
    assign rd_idx  = newest_q - k_q;
    assign prod    = PW'(coef_q[k_q]) * PW'(samp_q[rd_idx]);
    assign shifted = acc_q >>> (COEF_WIDTH - 2);
    assign sat_out = shifted > SAT_MAX ? {1'b0, {(DATA_WIDTH-1){1'b1}}} :
                     shifted < SAT_MIN ? {1'b1, {(DATA_WIDTH-1){1'b0}}} :
                     shifted[DATA_WIDTH-1:0];

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        k_d          = k_q;
        wr_ptr_d     = wr_ptr_q;
        newest_d     = newest_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        overrun_d    = strobe & ~idle;
        case (state_q)
            IDLE: if (take) begin
                state_d  = MAC;
                acc_d    = '0;
                k_d      = '0;
                newest_d = wr_ptr_q;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            MAC: begin
                acc_d   = acc_q + ACC_WIDTH'(prod);
                k_d     = k_q + 1'b1;
                state_d = k_q == AW'(NUM_TAPS - 1) ? DONE : MAC;
            end
            DONE: begin
                state_d      = IDLE;
                data_out_d   = sat_out;
                data_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= IDLE;
            data_clk_q   <= 1'b0;
            armed_q      <= 1'b0;
            wr_ptr_q     <= '0;
            newest_q     <= '0;
            k_q          <= '0;
            acc_q        <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_clk_q   <= bus.data_clk;
            armed_q      <= armed_q | ~bus.data_clk;
            wr_ptr_q     <= wr_ptr_d;
            newest_q     <= newest_d;
            k_q          <= k_d;
            acc_q        <= acc_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    // Reset restores an empty history and unity pass-through coefficients
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                samp_q[i] <= '0;
                coef_q[i] <= i == 0 ? COEF_WIDTH'(1) << (COEF_WIDTH - 2) : '0;
            end
        end else begin
            if (take) samp_q[wr_ptr_q] <= bus.data_in;
            if (bus.coef_we && idle) coef_q[bus.coef_addr] <= bus.coef_data;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.busy       = ~idle;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_cic_comp_fir.sv
// tb_cic_comp_fir: directed checks of pass-through, step, saturation, rounding,
// overrun, mid-MAC reset and coefficient write gating.
module tb_cic_comp_fir;
    logic clk = 1'b0;
    logic arst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    cic_comp_fir_if #(.DATA_WIDTH(12), .COEF_WIDTH(16), .NUM_TAPS(16)) bus ();

    cic_comp_fir #(.DATA_WIDTH(12), .COEF_WIDTH(16), .NUM_TAPS(16), .ACC_WIDTH(40)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input logic signed [31:0] exp, input int n0);
        int n = n0;
        while (!bus.data_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, n, 17);
        chk(tag, bus.data_out, exp);
        @(negedge clk);
        chk({tag, " pulse"}, {31'd0, bus.data_valid}, 0);
    endtask

    task automatic sample(input logic signed [11:0] v, input logic signed [31:0] exp, input string tag);
        bus.data_in  = v;
        bus.data_clk = 1'b1;
        @(negedge clk);
        bus.data_clk = 1'b0;
        wait_valid(tag, exp, 0);
    endtask

    task automatic coef_write(input int addr, input logic signed [15:0] val);
        bus.coef_we   = 1'b1;
        bus.coef_addr = 4'(addr);
        bus.coef_data = val;
        @(negedge clk);
        bus.coef_we   = 1'b0;
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int seen;
        arst_n        = 1'b0;
        bus.data_in   = '0;
        bus.data_clk  = 1'b1;
        bus.coef_we   = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        repeat (2) @(negedge clk);
        chk("rst data_out", bus.data_out, 0);
        chk("rst data_valid", {31'd0, bus.data_valid}, 0);
        chk("rst busy", {31'd0, bus.busy}, 0);
        chk("rst overrun", {31'd0, bus.overrun}, 0);
        arst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("high at release busy", {31'd0, bus.busy}, 0);
        bus.data_clk = 1'b0;
        @(negedge clk);

        sample(12'sd100, 100, "pass");

        coef_write(0, 16'sd8192);
        sample(-12'sd3, -2, "floor neg");
        sample(12'sd3, 1, "floor pos");

        do_reset();
        for (int i = 0; i < 4; i++) coef_write(i, 16'sd16384);
        sample(12'sd500, 500, "step1");
        sample(12'sd500, 1000, "step2");
        sample(12'sd500, 1500, "step3");
        sample(12'sd500, 2000, "step4");
        sample(12'sd500, 2000, "step5");

        do_reset();
        for (int i = 0; i < 16; i++) coef_write(i, 16'sd16384);
        sample(12'sd2047, 2047, "sat pos1");
        sample(12'sd2047, 2047, "sat pos2");
        sample(12'sd2047, 2047, "sat pos3");
        do_reset();
        for (int i = 0; i < 16; i++) coef_write(i, 16'sd16384);
        sample(-12'sd2048, -2048, "sat neg1");
        sample(-12'sd2048, -2048, "sat neg2");

        do_reset();
        coef_write(1, 16'sd16384);
        bus.data_in  = 12'sd100;
        bus.data_clk = 1'b1;
        @(negedge clk);
        bus.data_clk = 1'b0;
        repeat (4) @(negedge clk);
        bus.data_in  = 12'sd200;
        bus.data_clk = 1'b1;
        @(negedge clk);
        chk("overrun pulse", {31'd0, bus.overrun}, 1);
        bus.data_clk = 1'b0;
        @(negedge clk);
        chk("overrun one cycle", {31'd0, bus.overrun}, 0);
        chk("busy during mac", {31'd0, bus.busy}, 1);
        wait_valid("ovr first", 100, 6);
        sample(12'sd300, 400, "ovr dropped");

        coef_write(0, 16'sd0);
        bus.data_in  = 12'sd555;
        bus.data_clk = 1'b1;
        @(negedge clk);
        bus.data_clk = 1'b0;
        repeat (7) @(negedge clk);
        arst_n = 1'b0;
        #1;
        chk("midmac data_out", bus.data_out, 0);
        chk("midmac busy", {31'd0, bus.busy}, 0);
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.data_valid) seen = 1;
        end
        chk("midmac no valid", seen, 0);
        sample(12'sd100, 100, "after midmac");

        bus.data_in  = 12'sd100;
        bus.data_clk = 1'b1;
        @(negedge clk);
        bus.data_clk  = 1'b0;
        bus.coef_we   = 1'b1;
        bus.coef_addr = 4'd0;
        bus.coef_data = 16'sd0;
        @(negedge clk);
        bus.coef_we = 1'b0;
        wait_valid("busy write", 100, 1);
        sample(12'sd77, 77, "busy write ignored");
        coef_write(0, 16'sd0);
        sample(12'sd88, 0, "idle write");

        bus.data_in   = 12'sd40;
        bus.data_clk  = 1'b1;
        bus.coef_we   = 1'b1;
        bus.coef_addr = 4'd0;
        bus.coef_data = 16'sd8192;
        @(negedge clk);
        bus.data_clk = 1'b0;
        bus.coef_we  = 1'b0;
        wait_valid("same edge write", 20, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cic_comp_fir.md
CIC_COMP_FIR -- requirements
Module: cic_comp_fir

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, sample width in and out (signed).
REQ-002 SHALL have parameter COEF_WIDTH, default 16, signed coefficient width, Q2.(COEF_WIDTH-2).
REQ-003 SHALL have parameter NUM_TAPS, default 16, tap count; power of two, at least 2.
REQ-004 SHALL have parameter ACC_WIDTH, default 40, signed accumulator width.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port arst_n, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port data_in, input, DATA_WIDTH bits, signed decimated sample from the upstream CIC.
REQ-008 SHALL have port data_clk, input, 1 bit, upstream decimated sample clock (a level in the clk domain); each rising edge marks one new sample.
REQ-009 SHALL have port coef_we, input, 1 bit, coefficient write strobe.
REQ-010 SHALL have port coef_addr, input, $clog2(NUM_TAPS) bits, tap index.
REQ-011 SHALL have port coef_data, input, COEF_WIDTH bits, signed coefficient value.
REQ-012 SHALL have port data_out, output, DATA_WIDTH bits, signed registered filter output.
REQ-013 SHALL have port data_valid, output, 1 bit, one-cycle pulse when data_out updates.
REQ-014 SHALL have port busy, output, 1 bit, high whenever the FSM is not in IDLE.
REQ-015 SHALL have port overrun, output, 1 bit, one-cycle pulse when a sample is dropped.

Function
REQ-016 SHALL register data_clk as data_clk_q; a strobe is any edge where data_clk=1 and data_clk_q=0.
REQ-017 SHALL use the FSM states IDLE, MAC and DONE, with these transitions: IDLE->MAC on strobe; MAC->DONE after NUM_TAPS MAC cycles; DONE->IDLE unconditionally.
REQ-018 SHALL, on a strobe edge in IDLE (edge E), do all of the following: write data_in into the circular buffer at wr_ptr, advance wr_ptr by 1 modulo NUM_TAPS, clear acc, and set k=0.
REQ-019 SHALL, on each MAC edge (E+1..E+NUM_TAPS), compute acc += coef[k] * x[n-k], where x[n-k] = buf[(newest_ptr - k) mod NUM_TAPS], then increment k.
REQ-020 SHALL sign-extend the full COEF_WIDTH+DATA_WIDTH product to ACC_WIDTH; acc wraps in two's complement (no saturation on acc).
REQ-021 SHALL, on the DONE edge (E+NUM_TAPS+1), load data_out with sat(acc >>> (COEF_WIDTH-2)), and data_valid SHALL be 1 for exactly the following cycle.
REQ-022 SHALL define sat() as a clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; the shift truncates toward negative infinity.
REQ-023 SHALL hold data_out between updates.
REQ-024 SHALL give a latency from strobe edge E to data_valid high of NUM_TAPS+1 clk cycles.
REQ-025 SHALL, on a strobe while busy=1, drop the sample (buffer and wr_ptr unchanged), pulse overrun for one cycle, and leave the current computation unaffected.
REQ-026 SHALL write coef_data to coef[coef_addr] on the next edge when coef_we=1 and busy=0; writes while busy=1 SHALL be ignored.
REQ-027 SHALL process a strobe and a coef_we arriving on the same IDLE edge together; the write takes effect before the first MAC cycle.
REQ-028 SHALL rely on the upstream decimation ratio being at least NUM_TAPS+2 clk cycles per strobe; below that rate, overrun applies.

Reset
REQ-029 SHALL, while arst_n=0 and asynchronously, set: state=IDLE; data_out=0; data_valid=0; busy=0; overrun=0; data_clk_q=0; acc=0; k=0; wr_ptr=0.
REQ-030 SHALL, under the same reset, clear all buffer entries to 0, set coef[0]=2^(COEF_WIDTH-2), and set all other coefs to 0 (pass-through).
REQ-031 SHALL, on reset assertion mid-MAC, abandon the computation; no data_valid pulse is produced for it.
REQ-032 SHALL NOT treat a data_clk already high when arst_n is released as a strobe until data_clk goes low and then high again.

Verification
REQ-033 SHALL verify reset pass-through: default coefs, data_in=100 on a strobe -> data_out=100, data_valid high exactly at E+17.
REQ-034 SHALL verify step response: coef[0..3]=16384 and others 0, data_in=500 on successive strobes -> data_out 500, 1000, 1500, 2000, 2000.
REQ-035 SHALL verify saturation: all 16 coefs=16384 -> input 2047 repeated gives 2047, 2047, ... (clamped); input -2048 repeated gives -2048.
REQ-036 SHALL verify overrun: second strobe 5 cycles after E -> overrun pulse; first output unchanged; dropped sample absent from the next output.
REQ-037 SHALL verify reset mid-MAC: arst_n low at E+8 -> data_out=0 with no data_valid; after release, 100 on a strobe gives 100 (buffer cleared, pass-through coefs restored).
REQ-038 SHALL verify ignored write: coef_we to tap 0 with value 0 during MAC is ignored, so the next output still equals its input; the same write in IDLE then gives output 0.
